// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
//  Module      : data_cache
//  Description : Direct-mapped, write-through, no-write-allocate data cache
//                between the core load/store path and word-addressed memory.
//                Read hits answer combinationally; a read miss costs one
//                stall cycle while the word is fetched. Writes go straight
//                through to memory and update the line only on a hit.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_cache #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int INDEX_BITS    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [1:0]               WE,
  input  logic [ADDRESS_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0]    WD,
  output logic [DATA_WIDTH-1:0]    RD,
  output logic                     stall,
  output logic [1:0]               mem_WE,
  output logic [ADDRESS_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0]    mem_WD,
  input  logic [DATA_WIDTH-1:0]    mem_RD,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int LINES    = 2 ** INDEX_BITS;
  localparam int TAG_BITS = ADDRESS_WIDTH - INDEX_BITS;

  localparam logic [1:0] WE_READ = 2'b00;
  localparam logic [1:0] WE_WORD = 2'b01;
  localparam logic [1:0] WE_HALF = 2'b10;
  localparam logic [1:0] WE_BYTE = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [LINES-1:0]         valid_q;
  logic [TAG_BITS-1:0]      tag_q  [LINES];
  logic [DATA_WIDTH-1:0]    data_q [LINES];
  logic [ADDRESS_WIDTH-1:0] fill_addr_q, fill_addr_d;
  logic [31:0]              hit_count_q, miss_count_q;

  logic [INDEX_BITS-1:0]    w_index;
  logic [TAG_BITS-1:0]      w_tag;
  logic [INDEX_BITS-1:0]    w_fill_index;
  logic [TAG_BITS-1:0]      w_fill_tag;
  logic                     w_hit;
  logic                     w_hit_inc;
  logic                     w_miss_inc;
  logic                     w_write_hit;
  logic                     w_fill;
  logic [DATA_WIDTH-1:0]    w_merged;

  assign w_index      = A[INDEX_BITS-1:0];
  assign w_tag        = A[ADDRESS_WIDTH-1:INDEX_BITS];
  assign w_fill_index = fill_addr_q[INDEX_BITS-1:0];
  assign w_fill_tag   = fill_addr_q[ADDRESS_WIDTH-1:INDEX_BITS];
  assign w_hit        = req && valid_q[w_index] && (tag_q[w_index] == w_tag);

  assign mem_WD     = WD;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Merge store data into the cached word using the same lane rules as memory.
  always_comb begin
    w_merged = data_q[w_index];
    case (WE)
      WE_WORD: w_merged        = WD;
      WE_HALF: w_merged[15:0]  = WD[15:0];
      WE_BYTE: w_merged[7:0]   = WD[7:0];
      default: w_merged        = data_q[w_index];
    endcase
  end

  // Next-state and output decode; reset forces a quiet interface.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    stall       = 1'b0;
    mem_WE      = WE_READ;
    mem_A       = A;
    RD          = '0;
    w_hit_inc   = 1'b0;
    w_miss_inc  = 1'b0;
    w_write_hit = 1'b0;
    w_fill      = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (WE == WE_READ) begin
              if (w_hit) begin
                RD        = data_q[w_index];
                w_hit_inc = 1'b1;
              end else begin
                stall       = 1'b1;
                w_miss_inc  = 1'b1;
                fill_addr_d = A;
                state_d     = FILL;
              end
            end else begin
              mem_WE      = WE;
              w_write_hit = w_hit;
            end
          end
        end
        FILL: begin
          // Core inputs are ignored here; the latched address drives memory.
          mem_A   = fill_addr_q;
          RD      = mem_RD;
          w_fill  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state, valid bits and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fill_addr_q  <= '0;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      if (w_fill) begin
        valid_q[w_fill_index] <= 1'b1;
      end
      if (w_hit_inc && (hit_count_q != 32'hFFFF_FFFF)) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (w_miss_inc && (miss_count_q != 32'hFFFF_FFFF)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  // Line storage: fills replace the whole line, write hits merge lanes.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      tag_q[w_fill_index]  <= w_fill_tag;
      data_q[w_fill_index] <= mem_RD;
    end else if (w_write_hit) begin
      data_q[w_index] <= w_merged;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_cache
//  Description : Self-checking bench for data_cache with a behavioural data
//                memory, a vector table and a per-cycle expectation queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [1:0]    WE;
  logic [AW-1:0] A;
  logic [DW-1:0] WD;
  logic [DW-1:0] RD;
  logic          stall;
  logic [1:0]    mem_WE;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_WD;
  logic [DW-1:0] mem_RD;
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
  logic          init_mem;

  logic [DW-1:0] mem [256];

  data_cache #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_BITS(4)) dut (
    .clk(clk), .rst(rst), .req(req), .WE(WE), .A(A), .WD(WD),
    .RD(RD), .stall(stall), .mem_WE(mem_WE), .mem_A(mem_A),
    .mem_WD(mem_WD), .mem_RD(mem_RD),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] seed(input int i);
    logic [7:0] b;
    b = i[7:0];
    case (i)
      'h05:    return 32'hDEADBEEF;
      'h03:    return 32'h33333333;
      'h13:    return 32'h13131313;
      default: return {b, b, b, b};
    endcase
  endfunction

  // Behavioural data memory: combinational read, lane-masked write.
  assign mem_RD = mem[mem_A];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed(i);
    end else begin
      case (mem_WE)
        2'b01:   mem[mem_A]        <= mem_WD;
        2'b10:   mem[mem_A][15:0]  <= mem_WD[15:0];
        2'b11:   mem[mem_A][7:0]   <= mem_WD[7:0];
        default: ;
      endcase
    end
  end

  typedef struct {
    string         name;
    logic [1:0]    we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          miss;
    logic [DW-1:0] rd;
  } vec_t;

  typedef struct {
    string         name;
    logic          stall;
    logic [1:0]    mwe;
    logic [AW-1:0] ma;
    logic          chk_rd;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input string n, input logic [1:0] we, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic miss, input logic [DW-1:0] rd);
    vec_t v;
    v.name = n; v.we = we; v.a = a; v.wd = wd; v.miss = miss; v.rd = rd;
    return v;
  endfunction

  function automatic exp_t mke(input string n, input logic st, input logic [1:0] mwe,
                               input logic [AW-1:0] ma, input logic cr, input logic [DW-1:0] rd);
    exp_t e;
    e.name = n; e.stall = st; e.mwe = mwe; e.ma = ma; e.chk_rd = cr; e.rd = rd;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pop the expectation for the current cycle and compare the DUT outputs.
  task automatic check_cycle();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".stall"},  {31'b0, stall},  {31'b0, e.stall});
    chk({e.name, ".mem_WE"}, {30'b0, mem_WE}, {30'b0, e.mwe});
    chk({e.name, ".mem_A"},  {24'b0, mem_A},  {24'b0, e.ma});
    if (e.chk_rd) chk({e.name, ".RD"}, RD, e.rd);
  endtask

  task automatic do_access(input vec_t v);
    @(posedge clk); #1;
    req = 1'b1; WE = v.we; A = v.a; WD = v.wd;
    sb.push_back(mke(v.name, v.miss, v.we, v.a, (v.we == 2'b00) && !v.miss, v.rd));
    @(negedge clk);
    check_cycle();
    if (v.miss) begin
      sb.push_back(mke({v.name, "_fill"}, 1'b0, 2'b00, v.a, 1'b1, v.rd));
      @(posedge clk); #1;
      @(negedge clk);
      check_cycle();
    end
    @(posedge clk); #1;
    req = 1'b0; WE = 2'b00;
  endtask

  initial begin
    vecs[0]  = mk("rd_miss_05",   2'b00, 8'h05, 32'h0,        1'b1, 32'hDEADBEEF);
    vecs[1]  = mk("rd_hit_05",    2'b00, 8'h05, 32'h0,        1'b0, 32'hDEADBEEF);
    vecs[2]  = mk("wr_word_05",   2'b01, 8'h05, 32'h12345678, 1'b0, 32'h0);
    vecs[3]  = mk("rd_word_05",   2'b00, 8'h05, 32'h0,        1'b0, 32'h12345678);
    vecs[4]  = mk("wr_half_05",   2'b10, 8'h05, 32'hAAAA5555, 1'b0, 32'h0);
    vecs[5]  = mk("rd_half_05",   2'b00, 8'h05, 32'h0,        1'b0, 32'h12345555);
    vecs[6]  = mk("wr_byte_05",   2'b11, 8'h05, 32'h000000EE, 1'b0, 32'h0);
    vecs[7]  = mk("rd_byte_05",   2'b00, 8'h05, 32'h0,        1'b0, 32'h123455EE);
    vecs[8]  = mk("wr_nalloc_20", 2'b01, 8'h20, 32'hCAFEF00D, 1'b0, 32'h0);
    vecs[9]  = mk("rd_miss_20",   2'b00, 8'h20, 32'h0,        1'b1, 32'hCAFEF00D);
    vecs[10] = mk("conf_03_a",    2'b00, 8'h03, 32'h0,        1'b1, 32'h33333333);
    vecs[11] = mk("conf_13",      2'b00, 8'h13, 32'h0,        1'b1, 32'h13131313);
    vecs[12] = mk("conf_03_b",    2'b00, 8'h03, 32'h0,        1'b1, 32'h33333333);
    vecs[13] = mk("rd_hit_20",    2'b00, 8'h20, 32'h0,        1'b0, 32'hCAFEF00D);

    // Reset with a read request present: interface must stay quiet.
    rst = 1'b1; init_mem = 1'b1; req = 1'b1; WE = 2'b00; A = 8'h05; WD = '0;
    @(posedge clk); #1;
    init_mem = 1'b0;
    @(negedge clk);
    chk("rst.stall",  {31'b0, stall},  32'd0);
    chk("rst.mem_WE", {30'b0, mem_WE}, 32'd0);
    chk("rst.RD",     RD,              32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("rst.hit_count",  hit_count,  32'd0);
    chk("rst.miss_count", miss_count, 32'd0);

    for (int i = 0; i < 14; i++) do_access(vecs[i]);

    @(negedge clk);
    chk("tbl.hit_count",  hit_count,  32'd5);
    chk("tbl.miss_count", miss_count, 32'd5);
    chk("tbl.mem05",      mem[8'h05], 32'h123455EE);
    chk("tbl.mem20",      mem[8'h20], 32'hCAFEF00D);

    // Core inputs change during FILL; the fill must still use the latched address.
    @(posedge clk); #1;
    req = 1'b1; WE = 2'b00; A = 8'h07;
    sb.push_back(mke("hold_miss", 1'b1, 2'b00, 8'h07, 1'b0, 32'h0));
    @(negedge clk);
    check_cycle();
    @(posedge clk); #1;
    req = 1'b0; WE = 2'b01; A = 8'h09; WD = 32'hFFFFFFFF;
    sb.push_back(mke("hold_fill", 1'b0, 2'b00, 8'h07, 1'b1, 32'h07070707));
    @(negedge clk);
    check_cycle();
    @(posedge clk); #1;
    req = 1'b0; WE = 2'b00;
    do_access(mk("hold_rehit", 2'b00, 8'h07, 32'h0, 1'b0, 32'h07070707));
    @(negedge clk);
    chk("hold.mem09",       mem[8'h09], 32'h09090909);
    chk("hold.hit_count",   hit_count,  32'd6);
    chk("hold.miss_count",  miss_count, 32'd6);

    // Reset arriving in the FILL cycle abandons the fill.
    @(posedge clk); #1;
    req = 1'b1; WE = 2'b00; A = 8'h0A;
    @(negedge clk);
    chk("rfill.miss_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rfill.stall",  {31'b0, stall},  32'd0);
    chk("rfill.mem_WE", {30'b0, mem_WE}, 32'd0);
    chk("rfill.RD",     RD,              32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("rfill.hit_count",  hit_count,  32'd0);
    chk("rfill.miss_count", miss_count, 32'd0);
    do_access(mk("rfill_reread", 2'b00, 8'h0A, 32'h0, 1'b1, 32'h0A0A0A0A));
    do_access(mk("rfill_rehit",  2'b00, 8'h05, 32'h0, 1'b1, 32'h123455EE));
    @(negedge clk);
    chk("rfill.miss_after", miss_count, 32'd2);
    chk("rfill.hit_after",  hit_count,  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
